// File: rtl/bka_wb_initiator.sv
// rtl/bka_wb_initiator.sv - Wishbone B4 classic initiator driving the Brent-Kung adder register slave
// Optional: define BKA_INIT_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES strobe cycles without ack/err.

module bka_wb_initiator #(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [15:0] cmd_a_i,
  input  logic [15:0] cmd_b_i,
  input  logic        cmd_cin_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_sum_o,
  output logic        rsp_cout_o,
  output logic        rsp_err_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [2:0] {IDLE, WR_OP, WR_CIN, RD_RES, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        cin_q, cin_d;
  logic        cyc_d, we_d;
  logic [31:0] adr_d, dat_d;
  logic [15:0] sum_d;
  logic        cout_d, err_d;
  logic        in_bus, abort, tmo_hit;
  logic        unused_bits;

  assign unused_bits = ^{wbm_dat_i[31:17], TMO_LAST};
  assign in_bus      = (state_q == WR_OP) || (state_q == WR_CIN) || (state_q == RD_RES);
  assign cmd_ready_o = (state_q == IDLE);
  // A bus error beats a simultaneous ack; a timeout only fires when no ack arrived.
  assign abort       = in_bus && (wbm_err_i || (tmo_hit && !wbm_ack_i));

`ifdef BKA_INIT_TIMEOUT_EN
  logic [15:0] tmo_q;
  assign tmo_hit = (tmo_q == TMO_LAST);
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i)                          tmo_q <= '0;
    else if (!in_bus || (state_d != state_q)) tmo_q <= '0;
    else                                      tmo_q <= tmo_q + 16'd1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cin_d   = cin_q;
    sum_d   = rsp_sum_o;
    cout_d  = rsp_cout_o;
    err_d   = rsp_err_o;
    case (state_q)
      IDLE:    if (cmd_valid_i) begin
                 cin_d   = cmd_cin_i;
                 state_d = WR_OP;
               end
      WR_OP:   if (wbm_ack_i) state_d = WR_CIN;
      WR_CIN:  if (wbm_ack_i) state_d = RD_RES;
      RD_RES:  if (wbm_ack_i) begin
                 sum_d   = wbm_dat_i[15:0];
                 cout_d  = wbm_dat_i[16];
                 err_d   = 1'b0;
                 state_d = RESP;
               end
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = RESP;
      sum_d   = 16'h0000;
      cout_d  = 1'b0;
      err_d   = 1'b1;
    end

    // Bus outputs are registered, so they are decoded from the state being entered.
    cyc_d = (state_d == WR_OP) || (state_d == WR_CIN) || (state_d == RD_RES);
    we_d  = (state_d == WR_OP) || (state_d == WR_CIN);
    case (state_d)
      WR_OP: begin
        adr_d = BASE_ADDR;
        dat_d = (state_q == IDLE) ? {cmd_b_i, cmd_a_i} : wbm_dat_o;
      end
      WR_CIN: begin
        adr_d = BASE_ADDR + 32'd4;
        dat_d = {31'b0, cin_q};
      end
      RD_RES: begin
        adr_d = BASE_ADDR + 32'd8;
        dat_d = 32'h0;
      end
      default: begin
        adr_d = 32'h0;
        dat_d = 32'h0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      cin_q       <= 1'b0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= 4'h0;
      wbm_adr_o   <= 32'h0;
      wbm_dat_o   <= 32'h0;
      rsp_valid_o <= 1'b0;
      rsp_sum_o   <= 16'h0;
      rsp_cout_o  <= 1'b0;
      rsp_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cin_q       <= cin_d;
      wbm_cyc_o   <= cyc_d;
      wbm_stb_o   <= cyc_d;
      wbm_we_o    <= we_d;
      wbm_sel_o   <= cyc_d ? 4'hF : 4'h0;
      wbm_adr_o   <= adr_d;
      wbm_dat_o   <= dat_d;
      rsp_valid_o <= (state_d == RESP);
      rsp_sum_o   <= sum_d;
      rsp_cout_o  <= cout_d;
      rsp_err_o   <= err_d;
    end
  end

endmodule

// File: tb/tb_bka_wb_initiator.sv
// tb/tb_bka_wb_initiator.sv - self-checking bench for bka_wb_initiator with a transaction-level model and slave
module tb_bka_wb_initiator;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = 16'h0, cmd_b = 16'h0;
  logic        cmd_cin = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_sum;
  logic        rsp_cout, rsp_err;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o;
  logic [31:0] dat_i = 32'h0;
  logic        wb_ack = 1'b0, wb_err = 1'b0;

  always #5 clk = ~clk;

  bka_wb_initiator #(.BASE_ADDR(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_cin_i(cmd_cin),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_sum_o(rsp_sum), .rsp_cout_o(rsp_cout), .rsp_err_o(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(dat_i),
    .wbm_ack_i(wb_ack), .wbm_err_i(wb_err)
  );

  typedef struct {
    logic        is_wr;
    logic [31:0] adr;
    logic [31:0] dat;
    int          waits;
    bit          inj_err;
  } txn_t;

  txn_t        txq[$];
  int          checks = 0, failures = 0, cycle = 0, accepts = 0, wait_cnt = 0;
  bit          busy = 0, rsp_pend = 0;
  logic [16:0] res_next = 17'h0, e_res = 17'h0;
  logic        e_err = 1'b0;
  logic [31:0] s_op = 32'h0;
  logic        s_cin = 1'b0;
  int          cfg_w0 = 0, cfg_w1 = 0, cfg_w2 = 0, cfg_err_at = -1;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cycle);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=expired required=event cycle=%0d", name, cycle);
  endtask

  // Model, slave and checker: outputs are compared against the model state reached after
  // the previous rising edge, then the slave reply and model update for the next edge are decided.
  always @(negedge clk) begin
    bit   old_busy, old_pend;
    txn_t t;
    if (!rst_n) begin
      txq.delete();
      busy = 0; rsp_pend = 0; wait_cnt = 0;
      wb_ack = 1'b0; wb_err = 1'b0;
      chk("rst_cyc", 32'(cyc), 32'h0);
      chk("rst_stb", 32'(stb), 32'h0);
      chk("rst_we", 32'(we), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_adr", adr, 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_sum", 32'(rsp_sum), 32'h0);
      chk("rst_cout", 32'(rsp_cout), 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    end else begin
      old_busy = busy;
      old_pend = rsp_pend;
      chk("cyc", 32'(cyc), 32'(txq.size() > 0));
      chk("stb", 32'(stb), 32'(txq.size() > 0));
      chk("sel", 32'(sel), (txq.size() > 0) ? 32'hF : 32'h0);
      if (txq.size() > 0) begin
        chk("we", 32'(we), 32'(txq[0].is_wr));
        chk("adr", adr, txq[0].adr);
        chk("dat", dat_o, txq[0].dat);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(rsp_pend));
      if (rsp_pend) begin
        chk("rsp_sum", 32'(rsp_sum), 32'(e_res[15:0]));
        chk("rsp_cout", 32'(rsp_cout), 32'(e_res[16]));
        chk("rsp_err", 32'(rsp_err), 32'(e_err));
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));

      wb_ack = 1'b0;
      wb_err = 1'b0;
      dat_i  = $urandom;
      if (txq.size() > 0) begin
        if (wait_cnt < txq[0].waits) begin
          wait_cnt++;
`ifdef BKA_INIT_TIMEOUT_EN
          if (wait_cnt == TMO) begin
            txq.delete(); wait_cnt = 0;
            rsp_pend = 1; e_res = 17'h0; e_err = 1'b1;
          end
`endif
        end else begin
          t = txq.pop_front();
          wait_cnt = 0;
          if (t.inj_err) begin
            wb_err = 1'b1;
            wb_ack = 1'($urandom_range(0, 1));
            txq.delete();
            rsp_pend = 1; e_res = 17'h0; e_err = 1'b1;
          end else begin
            wb_ack = 1'b1;
            if (t.is_wr && t.adr == BASE) s_op = dat_o;
            else if (t.is_wr)             s_cin = dat_o[0];
            else dat_i = {15'($urandom_range(0, 32767)),
                          17'(s_op[15:0]) + 17'(s_op[31:16]) + 17'(s_cin)};
            if (txq.size() == 0) begin
              rsp_pend = 1; e_res = res_next; e_err = 1'b0;
            end
          end
        end
      end else begin
        wb_ack = ($urandom_range(0, 3) == 0);
        wb_err = ($urandom_range(0, 7) == 0);
      end

      if (old_pend && rsp_ready) begin
        rsp_pend = 0;
        busy = 0;
      end
      if (!old_busy && cmd_valid) begin
        busy = 1;
        accepts++;
        res_next = 17'(cmd_a) + 17'(cmd_b) + 17'(cmd_cin);
        txq.push_back('{is_wr:1'b1, adr:BASE,         dat:{cmd_b, cmd_a},    waits:cfg_w0, inj_err:(cfg_err_at == 0)});
        txq.push_back('{is_wr:1'b1, adr:BASE + 32'd4, dat:{31'b0, cmd_cin},  waits:cfg_w1, inj_err:(cfg_err_at == 1)});
        txq.push_back('{is_wr:1'b0, adr:BASE + 32'd8, dat:32'h0,             waits:cfg_w2, inj_err:(cfg_err_at == 2)});
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic c,
                       input int w0, input int w1, input int w2, input int err_at);
    cfg_w0 = w0; cfg_w1 = w1; cfg_w2 = w2; cfg_err_at = err_at;
    cmd_a = a; cmd_b = b; cmd_cin = c;
    cmd_valid = 1'b1;
  endtask

  task automatic wait_accept(input int base_acc);
    int n = 0;
    while (accepts == base_acc && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (accepts == base_acc) bound_fail("accept_wait");
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 3000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) bound_fail("rsp_wait");
  endtask

  initial begin
    int base, lat, n;
    repeat (3) @(posedge clk);
    #1;
    chk("init_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("init_cyc", 32'(cyc), 32'h0);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    base = accepts;
    issue(16'h1234, 16'h4321, 1'b0, 0, 0, 0, -1);
    wait_accept(base);
    wait_rsp(lat);
    chk("t1_latency", 32'(lat), 32'd3);
    chk("t1_sum", 32'(rsp_sum), 32'h5555);
    chk("t1_cout", 32'(rsp_cout), 32'h0);
    chk("t1_err", 32'(rsp_err), 32'h0);
    @(posedge clk); #1;

    base = accepts;
    issue(16'hFFFF, 16'h0001, 1'b1, 2, 2, 2, -1);
    wait_accept(base);
    wait_rsp(lat);
    chk("t2_latency", 32'(lat), 32'd9);
    chk("t2_sum", 32'(rsp_sum), 32'h0001);
    chk("t2_cout", 32'(rsp_cout), 32'h1);
    @(posedge clk); #1;

    base = accepts;
    issue(16'h00AA, 16'h0055, 1'b0, 0, 0, 0, 1);
    wait_accept(base);
    wait_rsp(lat);
    chk("t3_latency", 32'(lat), 32'd2);
    chk("t3_cyc", 32'(cyc), 32'h0);
    chk("t3_err", 32'(rsp_err), 32'h1);
    chk("t3_sum", 32'(rsp_sum), 32'h0);
    chk("t3_cout", 32'(rsp_cout), 32'h0);
    @(posedge clk); #1;

    rsp_ready = 1'b0;
    base = accepts;
    issue(16'h0F0F, 16'h00F0, 1'b1, 0, 1, 0, -1);
    wait_accept(base);
    wait_rsp(lat);
    base = accepts;
    issue(16'h8000, 16'h8000, 1'b0, 0, 0, 0, -1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_cmd_ready", 32'(cmd_ready), 32'h0);
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_sum", 32'(rsp_sum), 32'h1000);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("b2b_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("b2b_valid_low", 32'(rsp_valid), 32'h0);
    wait_accept(base);
    wait_rsp(lat);
    chk("b2b_latency", 32'(lat), 32'd3);
    chk("b2b_sum", 32'(rsp_sum), 32'h0000);
    chk("b2b_cout", 32'(rsp_cout), 32'h1);
    @(posedge clk); #1;

    base = accepts;
    issue(16'h0001, 16'h0002, 1'b0, 2000, 0, 0, -1);
    wait_accept(base);
`ifdef BKA_INIT_TIMEOUT_EN
    wait_rsp(lat);
    chk("tmo_latency", 32'(lat), 32'(TMO));
    chk("tmo_err", 32'(rsp_err), 32'h1);
    @(posedge clk); #1;
`else
    repeat (1000) @(posedge clk);
    #1;
    chk("notmo_stb", 32'(stb), 32'h1);
    chk("notmo_cyc", 32'(cyc), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("notmo_rst_cyc", 32'(cyc), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
`endif

    base = accepts;
    issue(16'h0003, 16'h0004, 1'b0, 1, 1, 5, -1);
    wait_accept(base);
    n = 0;
    while (!(cyc && !we && adr == BASE + 32'd8) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) bound_fail("rd_res_wait");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc", 32'(cyc), 32'h0);
    chk("mid_rst_stb", 32'(stb), 32'h0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

    for (int k = 0; k < 40; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      base = accepts;
      issue(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1);
      wait_accept(base);
      wait_rsp(lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk); #1;
    end

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
